// File: rtl/terminal_input_buffer.sv
// terminal_input_buffer
//   Character-input front end for the Apple-1 video terminal. Characters
//   offered by the host on rd/da are synchronised, acknowledged with a
//   programmable-width active-low rda_n pulse, and queued in a
//   first-word-fall-through FIFO that drains to the display controller
//   over a valid/ready port.
//
// Ports
//   clk_in    system clock, rising edge
//   clr_btn   asynchronous active-low reset
//   rd        host character (stable while da is high)
//   da        host data-available strobe (asynchronous level)
//   rda_n     active-low acknowledge to the host
//   flush     synchronous FIFO clear, active-high
//   ch_data   head-of-FIFO character
//   ch_valid  ch_data holds a character
//   ch_ready  consumer accepts ch_data this cycle
//   count     FIFO occupancy, 0..DEPTH
//   overrun   sticky: a character was held off because the FIFO was full
//
// Build option
//   TIB_CTRL_FILTER_EN  when defined, codes below 0x20 other than CR are
//                       acknowledged but not queued.

module terminal_input_buffer #(
  parameter int DATA_W     = 7,
  parameter int DEPTH      = 16,
  parameter int ACK_CYCLES = 4
) (
  input  logic                    clk_in,
  input  logic                    clr_btn,
  input  logic [DATA_W:1]         rd,
  input  logic                    da,
  output logic                    rda_n,
  input  logic                    flush,
  output logic [DATA_W:1]         ch_data,
  output logic                    ch_valid,
  input  logic                    ch_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_LOW} state_t;

  state_t          state;
  logic [CW-1:0]   ack_cnt;
  logic            da_meta;
  logic            da_s;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [DATA_W:1] mem [DEPTH];
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            keep_char;

  // Two-flop synchroniser for the asynchronous host strobe. rd needs none:
  // it is stable for as long as da is high.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge clr_btn) begin
    if (!clr_btn) begin
      da_meta <= 1'b0;
      da_s    <= 1'b0;
    end else begin
      da_meta <= da;
      da_s    <= da_meta;
    end
  end

  // Pointers carry an extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign ch_valid = !empty;
  assign ch_data  = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign pop      = ch_valid && ch_ready;

  // Control-code filter.
  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned, which would infer a latch.
  always_comb begin
    keep_char = 1'b1;
`ifdef TIB_CTRL_FILTER_EN
    if ((rd < DATA_W'(8'h20)) && (rd != DATA_W'(8'h0D)))
      keep_char = 1'b0;
`else
    keep_char = 1'b1;
`endif
  end

  // A push racing a flush is dropped; the handshake still completes.
  assign push = (state == CAPTURE) && keep_char && (!full || pop) && !flush;

  always_ff @(posedge clk_in or negedge clr_btn) begin
    if (!clr_btn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
    end
  end

  // NOTE: the storage array is reset so ch_data is a known value before the
  // first write; this is a small register file, not an inferred RAM macro.
  always_ff @(posedge clk_in or negedge clr_btn) begin
    if (!clr_btn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= rd;
    end
  end

  // Host handshake. rda_n is registered so it drops one edge after CAPTURE
  // and is low for exactly ACK_CYCLES cycles.
  always_ff @(posedge clk_in or negedge clr_btn) begin
    if (!clr_btn) begin
      state   <= IDLE;
      ack_cnt <= '0;
      rda_n   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (da_s && !full) state <= CAPTURE;
        end
        CAPTURE: begin
          ack_cnt <= CW'(ACK_CYCLES - 1);
          rda_n   <= 1'b0;
          state   <= ACK;
        end
        ACK: begin
          if (ack_cnt == '0) begin
            rda_n <= 1'b1;
            state <= WAIT_LOW;
          end else begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end
        WAIT_LOW: begin
          // A held da must fall before the next character is taken.
          if (!da_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (flush)
        overrun <= 1'b0;
      else if ((state == IDLE) && da_s && full)
        overrun <= 1'b1;
    end
  end

endmodule

// File: doc/terminal_input_buffer.md
# terminal_input_buffer

Parametrised character-input front end for the Apple-1 video terminal. It replaces the single-character `rd`/`da`/`rda_n` handshake with a synchronised, buffered interface. It accepts characters from the host strobe interface, acknowledges each one with a programmable-width `rda_n` pulse, and queues them in a FIFO. The FIFO drains into the display controller over a valid/ready port. Backpressure and a flush input let the terminal absorb bursts while it is busy scrolling or clearing.

## Interface
- `DATA_W`, 7: character width; the `rd` bus is `[DATA_W:1]`.
- `DEPTH`, 16: FIFO entries; must be a power of 2, minimum 2.
- `ACK_CYCLES`, 4: width of the `rda_n` low pulse in `clk_in` cycles, minimum 1.
- `clk_in`  in  1  system clock; all logic is on the rising edge.
- `clr_btn`  in  1  asynchronous active-low reset.
- `rd`  in  DATA_W  host character; must be stable while `da` is high.
- `da`  in  1  host data-available strobe; asynchronous, level.
- `rda_n`  out  1  active-low acknowledge to the host.
- `flush`  in  1  synchronous FIFO clear; active-high, one cycle is sufficient.
- `ch_data`  out  DATA_W  head-of-FIFO character.
- `ch_valid`  out  1  `ch_data` holds a character.
- `ch_ready`  in  1  consumer accepts `ch_data` this cycle.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `overrun`  out  1  sticky flag, set when a character is held off because the FIFO is full.

## Operation
- `da` passes through a 2-flop synchroniser to produce `da_s`. `rd` is sampled only in CAPTURE; no synchroniser is needed because `rd` is stable while `da` is high.
- Handshake FSM states: IDLE, CAPTURE, ACK, WAIT_LOW.
  - IDLE: if `da_s`=1 and the FIFO is not full, go to CAPTURE. If `da_s`=1 and the FIFO is full, stay in IDLE, hold `rda_n`=1 and set `overrun`.
  - CAPTURE: write `rd` into the FIFO (subject to the filter; see Configuration). Load the ack counter with ACK_CYCLES-1 and go to ACK.
  - ACK: `rda_n`=0. Decrement the counter. When the counter reaches 0, go to WAIT_LOW.
  - WAIT_LOW: `rda_n`=1. Wait for `da_s`=0, then return to IDLE. This prevents a held `da` from being captured twice.
- The FIFO is first-word-fall-through. It uses a circular buffer with read and write pointers of $clog2(DEPTH)+1 bits, where the MSB is the wrap bit.
  - empty: pointers equal.
  - full: indices equal and wrap bits differ.
- `ch_data` is taken from the memory at the read index. `ch_valid` = !empty. A pop happens when `ch_valid` and `ch_ready` are both high.
- Simultaneous push and pop in one cycle is legal, including when the FIFO is full (pop frees the slot; the push proceeds only if CAPTURE is active). When both happen, `count` is unchanged.
- `flush`: reset both pointers to 0 and clear `overrun`. The FSM is unaffected. A push in the same cycle as `flush` is discarded, but its acknowledge still completes.
- `overrun` is cleared only by `flush` or reset.

## Timing
- Reset values (while `clr_btn`=0, asynchronous):
  - FSM = IDLE, `rda_n`=1, synchroniser=0.
  - pointers=0, `count`=0, `ch_valid`=0, `overrun`=0.
  - `ch_data` is don't-care, but must not be X in the bench; reset the memory to 0.
- Latency from `da` rising (sampled at edge N):
  - `da_s` goes high at N+1 (the two flops capture at edges N and N+1).
  - CAPTURE at N+2.
  - `rda_n` falls after edge N+3 and stays low for exactly ACK_CYCLES cycles.
  - `ch_valid` rises after the write at edge N+3, in the same cycle `rda_n` falls.
- Pop: `ch_data`/`ch_valid` update the cycle after the pop edge.
- Minimum host character period: 2 + 1 + ACK_CYCLES + 2 (`da` fall synchronisation) + 1 cycles.
- If reset is asserted mid-ACK, `rda_n` returns to 1 immediately (asynchronously) and any character already queued is lost.

## Configuration
- `TIB_CTRL_FILTER_EN` defined: in CAPTURE, codes below 0x20 other than CR (0x0D) are not written to the FIFO. They are still acknowledged normally, and `count` is unchanged.
- `TIB_CTRL_FILTER_EN` undefined: every code is written to the FIFO.

## Test plan
- Reset then single character:
  - Stimulus: `clr_btn` low 100 ns then high; `rd`=0x41, `da`=1 held until `rda_n` falls.
  - Required: `rda_n` low for exactly 4 cycles; `ch_data`=0x41 with `ch_valid`=1 and `count`=1. With `ch_ready`=1, `ch_valid`=0 the next cycle.
- Burst to full:
  - Stimulus: `ch_ready`=0; send 17 characters 0x41..0x51.
  - Required: the first 16 are acknowledged and `count`=16. The 17th gets no `rda_n` pulse and `overrun`=1.
  - Then pulse `ch_ready` for one cycle: the 17th is captured and acknowledged, and `count` returns to 16.
- Wrap-around:
  - Stimulus: 40 characters with `ch_ready`=1 throughout.
  - Required: output order exactly matches input order across pointer wrap; `count` never exceeds 1.
- Held `da`:
  - Stimulus: `da` held high for 50 cycles with `rd`=0x0D.
  - Required: exactly one capture and one `rda_n` pulse.
- Flush and reset mid-operation:
  - Flush stimulus: `count`=5, assert `flush`. Required: `count`=0, `ch_valid`=0, `overrun`=0 the next cycle.
  - Reset stimulus: drop `clr_btn` during ACK. Required: `rda_n`=1 immediately.
- Filter:
  - Stimulus: send 0x07 then 0x0D.
  - Required with `TIB_CTRL_FILTER_EN`: both acknowledged, only 0x0D queued (`count`=1).
  - Required without `TIB_CTRL_FILTER_EN`: `count`=2.
